// File: rtl/mixer_pkg.sv
// Shared types and default sizing for the voice mixer control path.
package mixer_pkg;

  localparam int NUM_VOICES    = 12;
  localparam int NOTE_W        = 4;
  localparam int REL_W         = 8;
  localparam int AGE_W         = 4;
  localparam int RELEASE_TICKS = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } voice_state_t;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: lifecycle state, note, saturating age and release counter.
// Exposes its state after this cycle's note_off / tick so the top can pick
// an allocation target in the same cycle.
module voice_slot
  import mixer_pkg::*;
#(
  parameter int NOTE_W        = mixer_pkg::NOTE_W,
  parameter int REL_W         = mixer_pkg::REL_W,
  parameter int AGE_W         = mixer_pkg::AGE_W,
  parameter int RELEASE_TICKS = mixer_pkg::RELEASE_TICKS
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic               sample_tick_i,
  input  logic               note_on_i,
  input  logic               note_off_i,
  input  logic [NOTE_W-1:0]  note_id_i,
  input  logic               alloc_i,
  output voice_state_t       mid_state_o,
  output logic [NOTE_W-1:0]  note_o,
  output logic [AGE_W-1:0]   age_o,
  output logic               enable_o,
  output logic               start_o,
  output logic               next_idle_o
);

  localparam logic [REL_W-1:0] REL_INIT = REL_W'(RELEASE_TICKS);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  voice_state_t      state_q, state_d, mid_state;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic [REL_W-1:0]  cnt_q, cnt_d, mid_cnt;
  logic              enable_q, enable_d;
  logic              start_q, start_d;

  // Apply note_off and the release tick first; the on-allocation sees this view.
  always_comb begin
    mid_state = state_q;
    mid_cnt   = cnt_q;
    if (state_q == ACTIVE && note_off_i && note_q == note_id_i) begin
      if (RELEASE_TICKS == 0) begin
        mid_state = IDLE;
      end else begin
        mid_state = RELEASE;
        mid_cnt   = REL_INIT;
      end
    end else if (state_q == RELEASE && sample_tick_i) begin
      mid_cnt = cnt_q - 1'b1;
      if (cnt_q <= 1) mid_state = IDLE;
    end
  end

  // Allocation/retrigger overrides everything else; otherwise age the voice.
  always_comb begin
    state_d = mid_state;
    cnt_d   = mid_cnt;
    note_d  = note_q;
    age_d   = age_q;
    start_d = 1'b0;
    if (alloc_i) begin
      state_d = ACTIVE;
      note_d  = note_id_i;
      age_d   = '0;
      cnt_d   = '0;
      start_d = 1'b1;
    end else if (note_on_i && mid_state != IDLE && age_q != AGE_MAX) begin
      age_d = age_q + 1'b1;
    end
    enable_d = (state_d != IDLE);
  end

  // Slot registers.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q  <= IDLE;
      note_q   <= '0;
      age_q    <= '0;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      note_q   <= note_d;
      age_q    <= age_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      start_q  <= start_d;
    end
  end

  assign mid_state_o = mid_state;
  assign note_o      = note_q;
  assign age_o       = age_q;
  assign enable_o    = enable_q;
  assign start_o     = start_q;
  assign next_idle_o = (state_d == IDLE);

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator for the mixer: maps note events onto voice slots,
// retriggering held notes, else filling the lowest idle slot, else stealing
// the oldest releasing voice, else the oldest active voice.
module voice_allocator
  import mixer_pkg::*;
#(
  parameter int NUM_VOICES    = mixer_pkg::NUM_VOICES,
  parameter int NOTE_W        = mixer_pkg::NOTE_W,
  parameter int REL_W         = mixer_pkg::REL_W,
  parameter int RELEASE_TICKS = mixer_pkg::RELEASE_TICKS,
  parameter int AGE_W         = mixer_pkg::AGE_W
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         sample_tick,
  input  logic                         note_on,
  input  logic                         note_off,
  input  logic [NOTE_W-1:0]            note_id,
  output logic [NUM_VOICES-1:0]        voice_enable,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_start,
  output logic                         all_busy
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  voice_state_t                     mid_state [NUM_VOICES];
  logic [NUM_VOICES-1:0][NOTE_W-1:0] note_arr;
  logic [NUM_VOICES-1:0][AGE_W-1:0]  age_arr;
  logic [NUM_VOICES-1:0]             next_idle, alloc;
  logic [NUM_VOICES-1:0]             match_v, idle_v, rel_v, act_v;
  logic                              all_busy_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
      voice_slot #(
        .NOTE_W        (NOTE_W),
        .REL_W         (REL_W),
        .AGE_W         (AGE_W),
        .RELEASE_TICKS (RELEASE_TICKS)
      ) u_slot (
        .clk_i         (clk),
        .nrst_i        (nrst),
        .sample_tick_i (sample_tick),
        .note_on_i     (note_on),
        .note_off_i    (note_off),
        .note_id_i     (note_id),
        .alloc_i       (alloc[gi]),
        .mid_state_o   (mid_state[gi]),
        .note_o        (note_arr[gi]),
        .age_o         (age_arr[gi]),
        .enable_o      (voice_enable[gi]),
        .start_o       (voice_start[gi]),
        .next_idle_o   (next_idle[gi])
      );
    end
  endgenerate

  assign voice_note = note_arr;

  // Classify each slot as seen after note_off and tick processing.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      match_v[i] = (mid_state[i] != IDLE) && (note_arr[i] == note_id);
      idle_v[i]  = (mid_state[i] == IDLE);
      rel_v[i]   = (mid_state[i] == RELEASE);
      act_v[i]   = (mid_state[i] == ACTIVE);
    end
  end

  // Priority encoders plus oldest-voice search; strict '>' keeps the lowest index on ties.
  always_comb begin
    logic [IDX_W-1:0] match_idx, idle_idx, rel_idx, act_idx, tgt;
    logic [AGE_W-1:0] rel_age, act_age;
    logic             rel_found, act_found, do_alloc;
    match_idx = '0;
    idle_idx  = '0;
    rel_idx   = '0;
    act_idx   = '0;
    rel_age   = '0;
    act_age   = '0;
    rel_found = 1'b0;
    act_found = 1'b0;
    tgt       = '0;
    do_alloc  = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (match_v[i]) match_idx = IDX_W'(i);
      if (idle_v[i])  idle_idx  = IDX_W'(i);
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (rel_v[i] && (!rel_found || age_arr[i] > rel_age)) begin
        rel_found = 1'b1;
        rel_age   = age_arr[i];
        rel_idx   = IDX_W'(i);
      end
      if (act_v[i] && (!act_found || age_arr[i] > act_age)) begin
        act_found = 1'b1;
        act_age   = age_arr[i];
        act_idx   = IDX_W'(i);
      end
    end
    if (|match_v) begin
      tgt = match_idx; do_alloc = note_on;
    end else if (|idle_v) begin
      tgt = idle_idx;  do_alloc = note_on;
    end else if (rel_found) begin
      tgt = rel_idx;   do_alloc = note_on;
    end else if (act_found) begin
      tgt = act_idx;   do_alloc = note_on;
    end
    for (int i = 0; i < NUM_VOICES; i++) begin
      alloc[i] = do_alloc && (tgt == IDX_W'(i));
    end
  end

  // Registered busy flag reflects the post-update slot states.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) all_busy_q <= 1'b0;
    else       all_busy_q <= ~|next_idle;
  end

  assign all_busy = all_busy_q;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int NV = 12;
  localparam int NW = 4;
  localparam int RT = 4;
  localparam int AMAX = 15;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              sample_tick = 1'b0;
  logic              note_on = 1'b0;
  logic              note_off = 1'b0;
  logic [NW-1:0]     note_id = '0;
  logic [NV-1:0]     voice_enable;
  logic [NV*NW-1:0]  voice_note;
  logic [NV-1:0]     voice_start;
  logic              all_busy;

  int checks = 0;
  int failures = 0;

  // reference model: 0 = idle, 1 = playing, 2 = releasing
  int m_st [NV];
  int m_note [NV];
  int m_age [NV];
  int m_cnt [NV];
  bit m_start [NV];

  voice_allocator #(
    .NUM_VOICES(NV), .NOTE_W(NW), .REL_W(8), .RELEASE_TICKS(RT), .AGE_W(4)
  ) dut (
    .clk(clk), .nrst(nrst), .sample_tick(sample_tick), .note_on(note_on),
    .note_off(note_off), .note_id(note_id), .voice_enable(voice_enable),
    .voice_note(voice_note), .voice_start(voice_start), .all_busy(all_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_st[i] = 0; m_note[i] = 0; m_age[i] = 0; m_cnt[i] = 0; m_start[i] = 0;
    end
  endfunction

  function automatic void model_cycle(bit on, bit off, bit tick, int id);
    int tgt;
    int best;
    for (int i = 0; i < NV; i++) begin
      m_start[i] = 0;
      if (m_st[i] == 1 && off && m_note[i] == id) begin
        if (RT == 0) m_st[i] = 0;
        else begin m_st[i] = 2; m_cnt[i] = RT; end
      end else if (m_st[i] == 2 && tick) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) m_st[i] = 0;
      end
    end
    if (!on) return;
    tgt = -1;
    for (int i = 0; i < NV && tgt < 0; i++) if (m_st[i] != 0 && m_note[i] == id) tgt = i;
    for (int i = 0; i < NV && tgt < 0; i++) if (m_st[i] == 0) tgt = i;
    for (int s = 2; s >= 1 && tgt < 0; s--) begin
      best = -1;
      for (int i = 0; i < NV; i++)
        if (m_st[i] == s && (best < 0 || m_age[i] > m_age[best])) best = i;
      tgt = best;
    end
    for (int i = 0; i < NV; i++)
      if (i != tgt && m_st[i] != 0 && m_age[i] < AMAX) m_age[i]++;
    m_st[tgt] = 1; m_note[tgt] = id; m_age[tgt] = 0; m_start[tgt] = 1;
  endfunction

  task automatic compare_model(input string tag);
    logic [NV-1:0]    e_en, e_st;
    logic [NV*NW-1:0] e_note;
    bit               any_idle;
    any_idle = 0;
    for (int i = 0; i < NV; i++) begin
      e_en[i] = (m_st[i] != 0);
      e_st[i] = m_start[i];
      e_note[i*NW +: NW] = NW'(m_note[i]);
      if (m_st[i] == 0) any_idle = 1;
    end
    chk({tag, "_enable"}, 64'(voice_enable), 64'(e_en));
    chk({tag, "_note"},   64'(voice_note),   64'(e_note));
    chk({tag, "_start"},  64'(voice_start),  64'(e_st));
    chk({tag, "_busy"},   64'(all_busy),     64'(!any_idle));
  endtask

  task automatic step(input bit on, input bit off, input bit tick, input int id, input string tag);
    @(negedge clk);
    note_on = on; note_off = off; sample_tick = tick; note_id = NW'(id);
    @(posedge clk);
    model_cycle(on, off, tick, id);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    #3;
    nrst = 0; note_on = 0; note_off = 0; sample_tick = 0; note_id = '0;
    model_reset();
    #1;
    compare_model("reset");
    @(negedge clk);
    nrst = 1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // single note_on lands in voice 0
    step(1, 0, 0, 3, "on3");
    chk("on3_en", 64'(voice_enable), 64'h001);
    chk("on3_start", 64'(voice_start), 64'h001);
    chk("on3_note0", 64'(voice_note[3:0]), 64'd3);
    step(0, 0, 0, 0, "idle");
    chk("on3_pulse_end", 64'(voice_start), 64'h000);

    // fill all voices, then steal the oldest
    do_reset();
    for (int n = 0; n < NV; n++) step(1, 0, 0, n, "fill");
    chk("fill_en", 64'(voice_enable), 64'hFFF);
    chk("fill_busy", 64'(all_busy), 64'd1);
    step(1, 0, 0, 12, "steal");
    chk("steal_start", 64'(voice_start), 64'h001);
    chk("steal_note0", 64'(voice_note[3:0]), 64'd12);

    // release hold of RT ticks
    do_reset();
    step(1, 0, 0, 5, "rel_on");
    step(0, 1, 0, 5, "rel_off");
    chk("rel_off_en", 64'(voice_enable[0]), 64'd1);
    for (int t = 1; t <= RT; t++) begin
      step(0, 0, 1, 0, "rel_tick");
      chk("rel_tick_en", 64'(voice_enable[0]), (t < RT) ? 64'd1 : 64'd0);
      step(0, 0, 0, 0, "rel_gap");
    end

    // releasing voice is stolen before an older active voice
    do_reset();
    for (int n = 0; n < NV; n++) step(1, 0, 0, n, "pre");
    step(1, 0, 0, 0, "retrig0");
    step(0, 1, 0, 0, "off0");
    step(1, 0, 0, 13, "steal_rel");
    chk("steal_rel_start", 64'(voice_start), 64'h001);
    chk("steal_rel_note0", 64'(voice_note[3:0]), 64'd13);

    // same-cycle off+on of a held note retriggers in place
    do_reset();
    step(1, 0, 0, 0, "a");
    step(1, 0, 0, 1, "b");
    step(1, 0, 0, 7, "c");
    step(1, 1, 0, 7, "offon7");
    chk("offon7_start", 64'(voice_start), 64'h004);
    chk("offon7_en", 64'(voice_enable), 64'h007);

    // asynchronous reset while voices are releasing
    do_reset();
    step(1, 0, 0, 1, "r1");
    step(1, 0, 0, 2, "r2");
    step(0, 1, 0, 1, "r1off");
    step(0, 1, 0, 2, "r2off");
    do_reset();
    chk("areset_en", 64'(voice_enable), 64'h000);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, "post_reset");
      chk("post_reset_start", 64'(voice_start), 64'h000);
    end

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
